// File: rtl/usr_cmd_sequencer_pkg.sv
// usr_cmd_sequencer_pkg: shared encodings for the command sequencer that
// drives the 4-bit universal shift register.
package usr_cmd_sequencer_pkg;

    // Default register width; must match the driven shift register.
    localparam int DEF_WIDTH = 4;

    // Command opcodes share the shift register's ctrl encoding, so an
    // accepted opcode can be forwarded to ctrl unchanged.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/usr_step_counter.sv
// usr_step_counter: loadable down-counter holding the number of remaining
// steps of a command. The load value is the requested length, saturated
// to MAX_VAL with zero promoted to one; the counter then holds length-1 so
// that the zero flag marks the final step.
module usr_step_counter #(
    parameter int CNT_W   = 3,
    parameter int MAX_VAL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] cnt;

    // Effective length: 0 behaves as 1, anything above MAX_VAL clips.
    function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == '0) begin
            r = CNT_W'(1);
        end else if (v > MAX_C) begin
            r = MAX_C;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Remaining-step register: load on accept, count down while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= sat_len(load_val) - CNT_W'(1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/usr_cmd_sequencer.sv
// usr_cmd_sequencer: accepts hold/shift/load commands over valid/ready and
// expands each into N cycles of ctrl/d drive for the universal shift
// register, followed by a one-cycle done pulse.
// Optional feature macro: USR_SEQ_ABORT_EN (adds cmd_abort / aborted).
module usr_cmd_sequencer
    import usr_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       ctrl,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic             cmd_abort,
    output logic             aborted
`endif
);

    state_e           state, state_nxt;
    logic [1:0]       ctrl_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic [WIDTH-1:0] data_buf, data_buf_nxt;
    logic             busy_nxt, done_nxt, ready_nxt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             finish;
    logic [CNT_W-1:0] cnt_len;
`ifdef USR_SEQ_ABORT_EN
    logic             aborted_nxt;
`endif

    // Drive word for one step; the current serial bit is always word[0]
    // because the data buffer shifts right by one bit per step.
    function automatic logic [WIDTH-1:0] step_drive(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] v;
        v = '0;
        case (op)
            OP_LOAD: v = word;
            OP_SHL:  v[0] = word[0];
            OP_SHR:  v[WIDTH-1] = word[0];
            default: v = '0;
        endcase
        return v;
    endfunction

    // Loads always run exactly one step; count is ignored for them.
    assign cnt_len = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;

    usr_step_counter #(
        .CNT_W   (CNT_W),
        .MAX_VAL (WIDTH)
    ) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_len),
        .zero     (cnt_zero)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        ctrl_nxt     = ctrl;
        d_nxt        = d;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ready_nxt    = cmd_ready;
        data_buf_nxt = data_buf;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        finish       = cnt_zero;
`ifdef USR_SEQ_ABORT_EN
        aborted_nxt  = 1'b0;
        finish       = cnt_zero || cmd_abort;
`endif
        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                ctrl_nxt  = OP_HOLD;
                d_nxt     = '0;
                if (cmd_ready && cmd_valid) begin
                    state_nxt    = S_RUN;
                    busy_nxt     = 1'b1;
                    ready_nxt    = 1'b0;
                    data_buf_nxt = cmd_data;
                    ctrl_nxt     = cmd_op;
                    d_nxt        = step_drive(cmd_op, cmd_data);
                    cnt_load     = 1'b1;
                end
            end
            S_RUN: begin
                if (finish) begin
                    state_nxt = S_IDLE;
                    ctrl_nxt  = OP_HOLD;
                    d_nxt     = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
`ifdef USR_SEQ_ABORT_EN
                    // A final step that coincides with abort is a normal finish.
                    aborted_nxt = !cnt_zero;
`endif
                end else begin
                    cnt_dec      = 1'b1;
                    data_buf_nxt = data_buf >> 1;
                    d_nxt        = step_drive(ctrl, data_buf >> 1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the whole command context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ctrl      <= OP_HOLD;
            d         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
            data_buf  <= '0;
`ifdef USR_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ctrl      <= ctrl_nxt;
            d         <= d_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cmd_ready <= ready_nxt;
            data_buf  <= data_buf_nxt;
`ifdef USR_SEQ_ABORT_EN
            aborted   <= aborted_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// tb_usr_cmd_sequencer: sequencer driving a behavioural 4-bit universal
// shift register; q is checked in each done cycle.
// Optional feature macro: USR_SEQ_ABORT_EN.
module tb_usr_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic [1:0] ctrl;
    logic [3:0] d;
    logic       busy;
    logic       done;
`ifdef USR_SEQ_ABORT_EN
    logic       cmd_abort;
    logic       aborted;
`endif
    logic [3:0] q;

    int checks;
    int failures;
    int done_seen;

    usr_cmd_sequencer #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .ctrl      (ctrl),
        .d         (d),
        .busy      (busy),
        .done      (done)
`ifdef USR_SEQ_ABORT_EN
        ,
        .cmd_abort (cmd_abort),
        .aborted   (aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream universal shift register sharing clk and rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 4'b0000;
        else begin
            case (ctrl)
                2'b01:   q <= {q[2:0], d[0]};
                2'b10:   q <= {d[3], q[3:1]};
                2'b11:   q <= d;
                default: q <= q;
            endcase
        end
    end

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: effective length from the command rules.
    function automatic int model_len(input logic [1:0] op, input logic [2:0] cnt);
        if (op == 2'b11) return 1;
        if (cnt == 3'd0) return 1;
        if (int'(cnt) > 4) return 4;
        return int'(cnt);
    endfunction

    // Reference: register contents after n steps of a command.
    function automatic logic [3:0] model_q(input logic [3:0] q0, input logic [1:0] op,
                                           input logic [3:0] data, input int n);
        logic [3:0] r;
        r = q0;
        for (int k = 0; k < n; k++) begin
            case (op)
                2'b01:   r = {r[2:0], data[k]};
                2'b10:   r = {data[k], r[3:1]};
                2'b11:   r = data;
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Reference: ctrl/d drive expected on step k.
    function automatic logic [3:0] model_d(input logic [1:0] op, input logic [3:0] data, input int k);
        logic b;
        b = (k < 4) ? data[k] : 1'b0;
        case (op)
            2'b01:   return {3'b000, b};
            2'b10:   return {b, 3'b000};
            2'b11:   return data;
            default: return 4'b0000;
        endcase
    endfunction

    // Issue one command and follow it to its done cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                           input int exp_n, input logic [3:0] exp_q, input string tag);
        int waitc;
        int k;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_count = 3'($urandom);
        k = 0;
        while (busy === 1'b1 && k < 12) begin
            check({tag, " ctrl"}, 32'(ctrl), 32'(op));
            check({tag, " d"}, 32'(d), 32'(model_d(op, data, k)));
            k++;
            @(posedge clk); #1;
        end
        check({tag, " cycles"}, 32'(k), 32'(exp_n));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " q"}, 32'(q), 32'(exp_q));
        check({tag, " idle_ctrl"}, 32'(ctrl), 32'd0);
        check({tag, " idle_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] count;
        int         exp_n;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] mq;
        logic [1:0] rop;
        logic [3:0] rdat;
        logic [2:0] rcnt;
        int rn;
        int acc_cyc[$];
        int done_base;

        checks    = 0;
        failures  = 0;
        done_seen = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0000;
        cmd_count = 3'd0;
`ifdef USR_SEQ_ABORT_EN
        cmd_abort = 1'b0;
`endif

        vecs[0] = '{2'b11, 4'b1010, 3'd0, 1, 4'b1010};
        vecs[1] = '{2'b01, 4'b0001, 3'd2, 2, 4'b1010};
        vecs[2] = '{2'b10, 4'b0110, 3'd3, 3, 4'b1101};
        vecs[3] = '{2'b00, 4'b1111, 3'd0, 1, 4'b1101};
        vecs[4] = '{2'b01, 4'b0110, 3'd7, 4, 4'b0110};
        vecs[5] = '{2'b10, 4'b0011, 3'd5, 4, 4'b0011};
        vecs[6] = '{2'b00, 4'b1001, 3'd3, 3, 4'b0011};
        vecs[7] = '{2'b11, 4'b0101, 3'd6, 1, 4'b0101};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst ctrl", 32'(ctrl), 32'd0);
        check("rst d", 32'(d), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready before first edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready after first edge", 32'(cmd_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].exp_n, vecs[i].exp_q,
                    $sformatf("vec%0d", i));
        end

        // Randomized commands against the reference model.
        mq = 4'b0101;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            rop  = 2'($urandom);
            rdat = 4'($urandom);
            rcnt = 3'($urandom);
            rn   = model_len(rop, rcnt);
            mq   = model_q(mq, rop, rdat, rn);
            run_cmd(rop, rdat, rcnt, rn, mq, $sformatf("rnd%0d", i));
        end

        // cmd_valid held high: accepts only in IDLE, spaced N+1 apart.
        done_base = done_seen;
        cmd_op    = 2'b01;
        cmd_data  = 4'b0001;
        cmd_count = 3'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) acc_cyc.push_back(i);
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("stream accepts", 32'(acc_cyc.size()), 32'd5);
        for (int j = 1; j < acc_cyc.size(); j++) begin
            check($sformatf("stream spacing%0d", j), 32'(acc_cyc[j] - acc_cyc[j-1]), 32'd3);
        end
        check("stream dones", 32'(done_seen - done_base), 32'd5);
        check("stream q", 32'(q), 32'b1010);

        // Reset pulled low in the middle of a shift.
        cmd_op    = 2'b01;
        cmd_data  = 4'b1111;
        cmd_count = 3'd4;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("midrst busy before", 32'(busy), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("midrst ctrl", 32'(ctrl), 32'd0);
        check("midrst d", 32'(d), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready", 32'(cmd_ready), 32'd0);
        check("midrst q", 32'(q), 32'd0);
        done_base = done_seen;
        @(posedge clk); #1;
        check("midrst ready held", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst ready at release", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst ready after edge", 32'(cmd_ready), 32'd1);
        check("midrst busy after", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst dropped", 32'(done_seen - done_base), 32'd0);
        check("midrst q after", 32'(q), 32'd0);

`ifdef USR_SEQ_ABORT_EN
        // Abort during cycle 2 of a 4-step shift-left.
        cmd_op    = 2'b01;
        cmd_data  = 4'b1111;
        cmd_count = 3'd4;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        check("abort done", 32'(done), 32'd1);
        check("abort flag", 32'(aborted), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort ctrl", 32'(ctrl), 32'd0);
        check("abort q", 32'(q), 32'b0011);
        @(posedge clk); #1;
        check("abort done pulse", 32'(done), 32'd0);
        check("abort flag pulse", 32'(aborted), 32'd0);
        check("abort q held", 32'(q), 32'b0011);
        // Abort coinciding with the final step completes normally.
        cmd_op    = 2'b01;
        cmd_data  = 4'b0000;
        cmd_count = 3'd1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        check("abort last done", 32'(done), 32'd1);
        check("abort last flag", 32'(aborted), 32'd0);
        check("abort last q", 32'(q), 32'b0110);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
- Control stage directly upstream of the 4-bit universal shift register (ctrl/d/q/clk/rst block).
- Accepts one command at a time over a valid/ready handshake: hold N, shift-left N, shift-right N, or parallel load.
- Expands each command into a cycle-by-cycle ctrl/d drive sequence for the register, then pulses done.
- Lets upstream logic issue whole-word operations instead of toggling ctrl each cycle.

Parameters:
- WIDTH, 4, register width; must match the driven shift register.
- CNT_W, 3, width of cmd_count; equals clog2(WIDTH)+1.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous and active-low (clears all state while low).
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_op  input  2  00 hold, 01 shift left, 10 shift right, 11 load (same encoding as shift-register ctrl).
- cmd_data  input  WIDTH  load word, or serial bits for shifts (LSB first).
- cmd_count  input  CNT_W  cycles for hold/shift ops; ignored for load.
- ctrl  output  2  to shift register ctrl.
- d  output  WIDTH  to shift register d.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset while rst low: state IDLE; ctrl=00; d=0; busy=0; done=0; cmd_ready=0; internal count and data cleared.
- cmd_ready is registered. It rises on the first posedge after rst goes high, and is 1 whenever state is IDLE.
- FSM states: IDLE, RUN.
- Accept: on a posedge with state IDLE and cmd_valid=1. In the same edge:
  - state goes to RUN, busy=1, cmd_ready=0;
  - cmd_data is latched into an internal buffer;
  - ctrl gets cmd_op, and d gets the step-0 value.
- Effective length N:
  - load: N=1.
  - hold/shift: N = cmd_count, saturated to WIDTH.
  - cmd_count=0 is treated as N=1.
- Step k (0..N-1) drive values:
  - load: d = cmd_data.
  - shift left: d[0] = data[k], all other d bits 0.
  - shift right: d[WIDTH-1] = data[k], all other d bits 0.
  - hold: d = 0.
- RUN, per edge:
  - If the remaining count is 0: state goes to IDLE, ctrl=00, d=0, busy=0, done=1, cmd_ready=1.
  - Otherwise: decrement the count, advance k, and update d.
- ctrl/d are held at the command value for exactly N consecutive cycles, so the shift register samples exactly N active edges.
- done is high for exactly one cycle, the first IDLE cycle.
- Command throughput: a new command can be accepted at the edge ending the done cycle. Minimum spacing is N+1 cycles.
- cmd_valid/op/data/count are sampled only on the accept edge; changes during RUN are ignored.
- cmd_valid while not ready: not accepted, no side effects. Upstream keeps the command stable until accepted.
- Reset asserted mid-RUN: immediate return to reset values and the command is dropped. The shift register is reset by the same rst.

Optional Feature:
- Macro USR_SEQ_ABORT_EN.
- Defined: adds input cmd_abort (1 bit).
  - cmd_abort=1 in RUN: the next edge forces state to IDLE, ctrl=00, d=0, done=1, and sets output aborted=1 for that done cycle.
  - Ignored in IDLE.
  - If abort and the final step coincide, the result is treated as normal completion (aborted=0).
- Undefined: neither cmd_abort nor aborted exists; behaviour is exactly as above.

Decomposition:
- Shared package: op encodings (OP_HOLD=2'b00, OP_SHL=2'b01, OP_SHR=2'b10, OP_LOAD=2'b11), FSM state encodings (S_IDLE, S_RUN), default WIDTH.
- One sub-module, usr_step_counter: loadable down-counter with saturation and a zero flag.
- The FSM and d-mux stay in the top module.

Test Plan (bench instantiates sequencer driving the universal shift register; q checked in the done cycle):
- Reset, then load cmd_data=1010 -> ctrl=11 for 1 cycle, done after 1 cycle, q=1010.
- From q=1010, shift left count=2, data=01 -> ctrl=01 for 2 cycles, q goes 0101 then 1010, done once.
- From q=1010, shift right count=3, data=110 -> q goes 0101, 1010, 1101; busy high for 3 cycles.
- Hold count=0 -> treated as N=1, ctrl=00 for 1 cycle, q unchanged. Shift count=7 with WIDTH=4 -> saturates to exactly 4 active cycles.
- cmd_valid held high continuously -> commands accepted only in IDLE, spacing N+1, none lost or duplicated. rst pulled low mid-shift -> ctrl=00, busy=0, q=0000 immediately, cmd_ready=0 until the first edge after release.
- With USR_SEQ_ABORT_EN: abort on cycle 2 of shift-left count=4 -> exactly 2 shifts applied, done=1 and aborted=1 for one cycle.
